// File: rtl/bp_lce_req_queue_pkg.sv
// Shared types for the LCE request queue: request/message type encoding,
// the queue entry layout and block-size helper.
package bp_lce_req_queue_pkg;

    localparam int max_paddr_width_c = 64;
    localparam int max_way_width_c   = 8;

    typedef enum logic [3:0] {
        e_miss_load  = 4'd0,
        e_miss_store = 4'd1,
        e_uc_load    = 4'd2,
        e_uc_store   = 4'd3,
        e_amo_swap   = 4'd4,
        e_amo_add    = 4'd5,
        e_amo_xor    = 4'd6,
        e_amo_and    = 4'd7,
        e_amo_or     = 4'd8,
        e_amo_min    = 4'd9,
        e_amo_max    = 4'd10,
        e_amo_minu   = 4'd11,
        e_amo_maxu   = 4'd12
    } bp_req_type_e;

    typedef struct packed {
        bp_req_type_e                   req_type;
        logic [max_paddr_width_c-1:0]   addr;
        logic [2:0]                     size;
        logic [63:0]                    data;
        logic                           no_return;
        logic [max_way_width_c-1:0]     way;
        logic                           need_meta;
    } bp_lce_req_entry_s;

    // The network message type shares the cache request encoding.
    function automatic logic [3:0] req_to_msg_type(bp_req_type_e t);
        return 4'(t);
    endfunction

    function automatic logic req_is_miss(bp_req_type_e t);
        return (t == e_miss_load) || (t == e_miss_store);
    endfunction

    function automatic logic req_is_amo(bp_req_type_e t);
        return (t >= e_amo_swap) && (t <= e_amo_maxu);
    endfunction

    function automatic logic req_needs_meta(bp_req_type_e t);
        return !((t == e_uc_load) || (t == e_uc_store));
    endfunction

    function automatic int lg_block_size(int bytes);
        return $clog2(bytes);
    endfunction

endpackage

// File: rtl/bp_lce_req_credit_counter.sv
// Outstanding-transaction counter: +1 per sent message, -0..2 completions per
// cycle, saturating at zero.
module bp_lce_req_credit_counter
    import bp_lce_req_queue_pkg::*;
#(
    parameter int els_p = 8,
    localparam int cnt_w = $clog2(els_p + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             up_i,
    input  logic [1:0]       down_i,
    output logic [cnt_w-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int sum_w = cnt_w + 2;

    logic [cnt_w-1:0] count_r, count_n;
    logic [sum_w-1:0] inc, dec;

    assign inc = sum_w'(count_r) + sum_w'(up_i);
    assign dec = sum_w'(down_i);

    always_comb begin
        count_n = count_r;
        if (inc < dec) begin
            count_n = '0;
        end else begin
            count_n = cnt_w'(inc - dec);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else begin
            count_r <= count_n;
        end
    end

    assign count_o = count_r;
    assign full_o  = (count_r == cnt_w'(els_p));
    assign empty_o = (count_r == '0);

    // A completion with nothing outstanding means the cache lost track.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (down_i != 2'b00) |-> (count_r != '0));

endmodule

// File: rtl/bp_lce_req_queue.sv
// In-order LCE request queue with late metadata binding and credit tracking.
// Define BP_LCE_REQ_STATS_EN to enable the sent/stall statistic counters.
module bp_lce_req_queue
    import bp_lce_req_queue_pkg::*;
#(
    parameter int req_els_p             = 2,
    parameter int credits_p             = 8,
    parameter int non_excl_reads_p      = 0,
    parameter int paddr_width_p         = 40,
    parameter int block_size_in_bytes_p = 64,
    parameter int lce_id_width_p        = 4,
    parameter int cce_id_width_p        = 4,
    parameter int num_cce_p             = 1,
    parameter int assoc_p               = 8,
    localparam int lg_assoc = (assoc_p > 1) ? $clog2(assoc_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [lce_id_width_p-1:0] lce_id_i,
    input  logic                      uncached_mode_i,
    input  logic                      sync_done_i,

    input  logic                      cache_req_v_i,
    output logic                      cache_req_yumi_o,
    input  logic [3:0]                cache_req_type_i,
    input  logic [paddr_width_p-1:0]  cache_req_addr_i,
    input  logic [2:0]                cache_req_size_i,
    input  logic [63:0]               cache_req_data_i,
    input  logic                      cache_req_no_return_i,

    input  logic                      metadata_v_i,
    input  logic [lg_assoc-1:0]       metadata_way_i,

    input  logic                      cache_complete_i,
    input  logic                      uc_complete_i,
    output logic                      credits_full_o,
    output logic                      credits_empty_o,

    output logic                      lce_req_v_o,
    input  logic                      lce_req_ready_i,
    output logic [3:0]                lce_req_type_o,
    output logic [paddr_width_p-1:0]  lce_req_addr_o,
    output logic [2:0]                lce_req_size_o,
    output logic [63:0]               lce_req_data_o,
    output logic [lg_assoc-1:0]       lce_req_way_o,
    output logic                      lce_req_non_excl_o,
    output logic                      lce_req_amo_no_return_o,
    output logic [lce_id_width_p-1:0] lce_req_src_id_o,
    output logic [cce_id_width_p-1:0] lce_req_dst_id_o,

    output logic [31:0]               stat_sent_o,
    output logic [31:0]               stat_stall_o
);

    localparam int lg_block = lg_block_size(block_size_in_bytes_p);
    localparam int ptr_w    = (req_els_p > 1) ? $clog2(req_els_p) : 1;
    localparam int qcnt_w   = $clog2(req_els_p + 1);
    localparam int cred_w   = $clog2(credits_p + 1);

    bp_lce_req_entry_s mem [req_els_p];
    bp_lce_req_entry_s new_entry, head;

    logic [ptr_w-1:0]  wr_ptr_r, rd_ptr_r, meta_idx_r;
    logic [qcnt_w-1:0] count_r;
    logic              meta_pend_r;
    logic [cred_w-1:0] credit_count;

    bp_req_type_e      req_type;
    logic              mode_ok, queue_full, credit_ok;
    logic              enq, deq, meta_to_old;
    logic [63:0]       addr_ext;

    function automatic logic [ptr_w-1:0] ptr_inc(logic [ptr_w-1:0] p);
        return (32'(p) == 32'(req_els_p - 1)) ? '0 : ptr_w'(p + ptr_w'(1));
    endfunction

    assign req_type = bp_req_type_e'(cache_req_type_i);
    assign addr_ext = 64'(cache_req_addr_i);

    // Coherent misses need a synced, cached-mode LCE; everything else may run uncached.
    assign mode_ok    = req_is_miss(req_type) ? (sync_done_i & ~uncached_mode_i)
                                              : (sync_done_i | uncached_mode_i);
    assign queue_full = (count_r == qcnt_w'(req_els_p));
    assign credit_ok  = (32'(credit_count) + 32'(count_r)) < 32'(credits_p);

    assign cache_req_yumi_o = reset_n_i & cache_req_v_i & ~queue_full & credit_ok & mode_ok;
    assign enq = cache_req_yumi_o;

    always_comb begin
        new_entry           = '0;
        new_entry.req_type  = req_type;
        new_entry.no_return = cache_req_no_return_i;
        new_entry.need_meta = req_needs_meta(req_type);
        if (req_is_miss(req_type)) begin
            new_entry.addr = addr_ext & ~((64'd1 << lg_block) - 64'd1);
            new_entry.size = 3'(lg_block);
        end else begin
            new_entry.addr = addr_ext;
            new_entry.size = cache_req_size_i;
        end
        if (req_type >= e_uc_store) begin
            new_entry.data = cache_req_data_i;
        end
        if (new_entry.need_meta && metadata_v_i) begin
            new_entry.way       = max_way_width_c'(metadata_way_i);
            new_entry.need_meta = 1'b0;
        end
    end

    assign meta_to_old = metadata_v_i & meta_pend_r & ~(enq & req_needs_meta(req_type));

    // The free slot being written never aliases the pending entry, so both writes may coincide.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr_r] <= new_entry;
        end
        if (meta_to_old) begin
            mem[meta_idx_r].way       <= max_way_width_c'(metadata_way_i);
            mem[meta_idx_r].need_meta <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            meta_pend_r <= 1'b0;
            meta_idx_r  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (deq) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + qcnt_w'(1);
                2'b01:   count_r <= count_r - qcnt_w'(1);
                default: count_r <= count_r;
            endcase
            if (enq && new_entry.need_meta) begin
                meta_pend_r <= 1'b1;
                meta_idx_r  <= wr_ptr_r;
            end else if (meta_to_old) begin
                meta_pend_r <= 1'b0;
            end
        end
    end

    assign head        = mem[rd_ptr_r];
    assign lce_req_v_o = (count_r != '0) & ~head.need_meta;
    assign deq         = lce_req_v_o & lce_req_ready_i;

    assign lce_req_type_o          = req_to_msg_type(head.req_type);
    assign lce_req_addr_o          = head.addr[paddr_width_p-1:0];
    assign lce_req_size_o          = head.size;
    assign lce_req_data_o          = head.data;
    assign lce_req_way_o           = head.way[lg_assoc-1:0];
    assign lce_req_non_excl_o      = (head.req_type == e_miss_load) && (non_excl_reads_p != 0);
    assign lce_req_amo_no_return_o = head.no_return & req_is_amo(head.req_type);
    assign lce_req_src_id_o        = lce_id_i;

    if (num_cce_p > 1) begin : g_dst
        localparam int lg_cce = $clog2(num_cce_p);
        assign lce_req_dst_id_o = cce_id_width_p'(head.addr[lg_block +: lg_cce]);
    end else begin : g_dst_single
        assign lce_req_dst_id_o = '0;
    end

    bp_lce_req_credit_counter #(.els_p(credits_p)) credit_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .up_i      (deq),
        .down_i    ({cache_complete_i & uc_complete_i, cache_complete_i ^ uc_complete_i}),
        .count_o   (credit_count),
        .full_o    (credits_full_o),
        .empty_o   (credits_empty_o)
    );

`ifdef BP_LCE_REQ_STATS_EN
    logic [31:0] sent_r, stall_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sent_r  <= '0;
            stall_r <= '0;
        end else begin
            if (deq) begin
                sent_r <= sent_r + 32'd1;
            end
            if (lce_req_v_o && !lce_req_ready_i) begin
                stall_r <= stall_r + 32'd1;
            end
        end
    end

    assign stat_sent_o  = sent_r;
    assign stat_stall_o = stall_r;
`else
    assign stat_sent_o  = '0;
    assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_bp_lce_req_queue.sv
// Self-checking bench for bp_lce_req_queue: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_bp_lce_req_queue;

    localparam int REQ_ELS  = 2;
    localparam int CRED     = 4;
    localparam int NON_EXCL = 0;
    localparam int NCCE     = 4;
    localparam int BLK      = 64;

`ifdef BP_LCE_REQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  lce_id;
    logic        uncached_mode, sync_done;
    logic        req_v, req_yumi;
    logic [3:0]  req_type;
    logic [39:0] req_addr;
    logic [2:0]  req_size;
    logic [63:0] req_data;
    logic        req_no_return;
    logic        meta_v;
    logic [2:0]  meta_way;
    logic        cache_complete, uc_complete;
    logic        credits_full, credits_empty;
    logic        lce_v, lce_ready;
    logic [3:0]  lce_type;
    logic [39:0] lce_addr;
    logic [2:0]  lce_size;
    logic [63:0] lce_data;
    logic [2:0]  lce_way;
    logic        lce_non_excl, lce_no_return;
    logic [3:0]  lce_src, lce_dst;
    logic [31:0] stat_sent, stat_stall;

    always #5 clk = ~clk;

    bp_lce_req_queue #(
        .req_els_p(REQ_ELS), .credits_p(CRED), .non_excl_reads_p(NON_EXCL),
        .paddr_width_p(40), .block_size_in_bytes_p(BLK), .lce_id_width_p(4),
        .cce_id_width_p(4), .num_cce_p(NCCE), .assoc_p(8)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lce_id),
        .uncached_mode_i(uncached_mode), .sync_done_i(sync_done),
        .cache_req_v_i(req_v), .cache_req_yumi_o(req_yumi),
        .cache_req_type_i(req_type), .cache_req_addr_i(req_addr),
        .cache_req_size_i(req_size), .cache_req_data_i(req_data),
        .cache_req_no_return_i(req_no_return),
        .metadata_v_i(meta_v), .metadata_way_i(meta_way),
        .cache_complete_i(cache_complete), .uc_complete_i(uc_complete),
        .credits_full_o(credits_full), .credits_empty_o(credits_empty),
        .lce_req_v_o(lce_v), .lce_req_ready_i(lce_ready),
        .lce_req_type_o(lce_type), .lce_req_addr_o(lce_addr),
        .lce_req_size_o(lce_size), .lce_req_data_o(lce_data),
        .lce_req_way_o(lce_way), .lce_req_non_excl_o(lce_non_excl),
        .lce_req_amo_no_return_o(lce_no_return),
        .lce_req_src_id_o(lce_src), .lce_req_dst_id_o(lce_dst),
        .stat_sent_o(stat_sent), .stat_stall_o(stat_stall)
    );

    typedef struct {
        logic        req_v;
        logic [3:0]  typ;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
        logic        nr;
        logic        meta_v;
        logic [2:0]  way;
        logic        cc;
        logic        uc;
        logic        ready;
        logic        sync;
        logic        ucm;
    } stim_t;

    typedef struct {
        logic [3:0]  typ;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
        logic [2:0]  way;
        logic        non_excl;
        logic        nr;
        logic [3:0]  dst;
        logic        need_meta;
    } msg_t;

    typedef struct {
        stim_t       s;
        logic        e_yumi;
        logic        e_v;
        logic [3:0]  e_typ;
        logic [39:0] e_addr;
        logic [2:0]  e_size;
        logic [2:0]  e_way;
        logic        e_empty;
    } vec_t;

    int tests = 0;
    int fails = 0;

    msg_t mq[$];
    int   m_cred, m_sent, m_stall;
    logic last_exp_yumi;
    logic [3:0] sent_dst[$];

    logic        act_yumi, act_v, act_full, act_empty, act_nr;
    logic [3:0]  act_typ;
    logic [39:0] act_addr;
    logic [2:0]  act_size, act_way;
    logic [63:0] act_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: bound expired, got no progress, expected completion", name);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{req_v: 1'b0, typ: 4'd0, addr: 40'd0, size: 3'd0, data: 64'd0, nr: 1'b0,
              meta_v: 1'b0, way: 3'd0, cc: 1'b0, uc: 1'b0, ready: 1'b1, sync: 1'b1, ucm: 1'b0};
        return s;
    endfunction

    function automatic logic has_pending();
        foreach (mq[i]) if (mq[i].need_meta) return 1'b1;
        return 1'b0;
    endfunction

    function automatic msg_t mk_msg();
        msg_t m;
        int   t = int'(req_type);
        m.typ = req_type;
        if (t <= 1) begin
            m.addr = (req_addr / BLK) * BLK;
            m.size = 3'd6;
        end else begin
            m.addr = req_addr;
            m.size = req_size;
        end
        m.data      = (t >= 3) ? req_data : 64'd0;
        m.non_excl  = (t == 0) && (NON_EXCL != 0);
        m.nr        = (t >= 4) ? req_no_return : 1'b0;
        m.way       = 3'd0;
        m.need_meta = !(t == 2 || t == 3);
        m.dst       = 4'((m.addr / BLK) % NCCE);
        return m;
    endfunction

    task automatic applyStimulus(input stim_t s);
        req_v          = s.req_v;
        req_type       = s.typ;
        req_addr       = s.addr;
        req_size       = s.size;
        req_data       = s.data;
        req_no_return  = s.nr;
        meta_v         = s.meta_v;
        meta_way       = s.way;
        cache_complete = s.cc;
        uc_complete    = s.uc;
        lce_ready      = s.ready;
        sync_done      = s.sync;
        uncached_mode  = s.ucm;
    endtask

    // Compares DUT outputs with the model for the current cycle, then advances the model.
    task automatic checkOutput();
        int   qn = mq.size();
        logic is_miss, mode_ok, exp_v, bound;
        msg_t m;
        is_miss = (req_type <= 4'd1);
        mode_ok = is_miss ? (sync_done && !uncached_mode) : (sync_done || uncached_mode);
        last_exp_yumi = req_v && (qn < REQ_ELS) && ((m_cred + qn) < CRED) && mode_ok;
        exp_v = (qn > 0) && !mq[0].need_meta;

        chk("yumi", 64'(req_yumi), 64'(last_exp_yumi));
        chk("valid", 64'(lce_v), 64'(exp_v));
        chk("credits_full", 64'(credits_full), 64'(m_cred == CRED));
        chk("credits_empty", 64'(credits_empty), 64'(m_cred == 0));
        chk("stat_sent", 64'(stat_sent), STATS ? 64'(32'(m_sent)) : 64'd0);
        chk("stat_stall", 64'(stat_stall), STATS ? 64'(32'(m_stall)) : 64'd0);
        if (exp_v) begin
            chk("msg_type", 64'(lce_type), 64'(mq[0].typ));
            chk("msg_addr", 64'(lce_addr), 64'(mq[0].addr));
            chk("msg_size", 64'(lce_size), 64'(mq[0].size));
            chk("msg_data", lce_data, mq[0].data);
            chk("msg_way", 64'(lce_way), 64'(mq[0].way));
            chk("msg_non_excl", 64'(lce_non_excl), 64'(mq[0].non_excl));
            chk("msg_no_return", 64'(lce_no_return), 64'(mq[0].nr));
            chk("msg_src", 64'(lce_src), 64'(lce_id));
            chk("msg_dst", 64'(lce_dst), 64'(mq[0].dst));
        end

        if (exp_v && lce_ready) begin
            void'(mq.pop_front());
            m_sent++;
            m_cred++;
        end else if (exp_v) begin
            m_stall++;
        end
        m_cred = m_cred - int'(cache_complete) - int'(uc_complete);
        if (m_cred < 0) m_cred = 0;

        bound = 1'b0;
        if (last_exp_yumi) begin
            m = mk_msg();
            if (m.need_meta && meta_v) begin
                m.way       = meta_way;
                m.need_meta = 1'b0;
                bound       = 1'b1;
            end
            mq.push_back(m);
        end
        if (meta_v && !bound) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].need_meta) begin
                    mq[i].way       = meta_way;
                    mq[i].need_meta = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic step(input stim_t s);
        applyStimulus(s);
        #1;
        act_yumi  = req_yumi;
        act_v     = lce_v;
        act_full  = credits_full;
        act_empty = credits_empty;
        act_typ   = lce_type;
        act_addr  = lce_addr;
        act_size  = lce_size;
        act_data  = lce_data;
        act_way   = lce_way;
        act_nr    = lce_no_return;
        if (lce_v && lce_ready) sent_dst.push_back(lce_dst);
        checkOutput();
        @(negedge clk);
    endtask

    task automatic drain();
        stim_t s;
        for (int c = 0; c < 40; c++) begin
            if (mq.size() == 0 && m_cred == 0) return;
            s    = idle();
            s.cc = (m_cred > 0);
            s.uc = (m_cred > 1);
            step(s);
        end
        timeoutFail("drain");
    endtask

    // Presents one request until accepted; returns 0 if the bound expires.
    task automatic offer(input stim_t s, input int bound, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            step(s);
            if (last_exp_yumi) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    function automatic void modelReset();
        mq.delete();
        m_cred  = 0;
        m_sent  = 0;
        m_stall = 0;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t  vecs[5];
        stim_t s;
        logic  ok;
        int    idx;

        lce_id  = 4'h9;
        reset_n = 1'b0;
        s = idle();
        s.req_v = 1'b1;
        s.typ   = 4'd2;
        applyStimulus(s);
        modelReset();
        repeat (2) @(negedge clk);
        chk("reset_valid", 64'(lce_v), 64'd0);
        chk("reset_yumi", 64'(req_yumi), 64'd0);
        chk("reset_empty", 64'(credits_empty), 64'd1);
        chk("reset_full", 64'(credits_full), 64'd0);
        chk("reset_stat_sent", 64'(stat_sent), 64'd0);
        applyStimulus(idle());
        reset_n = 1'b1;
        @(negedge clk);

        // miss_load, way arrives one cycle later, sent two cycles after acceptance
        foreach (vecs[i]) begin
            vecs[i].s      = idle();
            vecs[i].e_yumi = 1'b0;
            vecs[i].e_v    = 1'b0;
            vecs[i].e_typ  = 4'd0;
            vecs[i].e_addr = 40'd0;
            vecs[i].e_size = 3'd0;
            vecs[i].e_way  = 3'd0;
            vecs[i].e_empty = 1'b1;
        end
        vecs[0].s.req_v = 1'b1;
        vecs[0].s.addr  = 40'h8000_0047;
        vecs[0].s.size  = 3'd3;
        vecs[0].e_yumi  = 1'b1;
        vecs[1].s.meta_v = 1'b1;
        vecs[1].s.way    = 3'd3;
        vecs[2].e_v     = 1'b1;
        vecs[2].e_addr  = 40'h8000_0040;
        vecs[2].e_size  = 3'd6;
        vecs[2].e_way   = 3'd3;
        vecs[3].s.cc    = 1'b1;
        vecs[3].e_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].s);
            chk($sformatf("tbl%0d_yumi", i), 64'(act_yumi), 64'(vecs[i].e_yumi));
            chk($sformatf("tbl%0d_valid", i), 64'(act_v), 64'(vecs[i].e_v));
            chk($sformatf("tbl%0d_empty", i), 64'(act_empty), 64'(vecs[i].e_empty));
            if (vecs[i].e_v) begin
                chk($sformatf("tbl%0d_type", i), 64'(act_typ), 64'(vecs[i].e_typ));
                chk($sformatf("tbl%0d_addr", i), 64'(act_addr), 64'(vecs[i].e_addr));
                chk($sformatf("tbl%0d_size", i), 64'(act_size), 64'(vecs[i].e_size));
                chk($sformatf("tbl%0d_way", i), 64'(act_way), 64'(vecs[i].e_way));
            end
        end

        // three uc_stores against a two-deep queue with the network stalled
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            s       = idle();
            s.ready = (c >= 3);
            s.req_v = 1'b1;
            s.typ   = 4'd3;
            s.addr  = 40'h100 + 40'(idx * 8);
            s.size  = 3'd3;
            s.data  = 64'hA0 + 64'(idx);
            step(s);
            if (c == 2) chk("third_store_held", 64'(act_yumi), 64'd0);
            if (last_exp_yumi) idx++;
        end
        if (idx < 3) timeoutFail("uc_store_accept");
        drain();

        // amo_add whose way arrives four cycles after acceptance
        s       = idle();
        s.req_v = 1'b1;
        s.typ   = 4'd5;
        s.addr  = 40'h12_3456_7808;
        s.size  = 3'd3;
        s.data  = 64'h5;
        s.nr    = 1'b1;
        offer(s, 5, ok);
        if (!ok) timeoutFail("amo_accept");
        for (int c = 0; c < 4; c++) begin
            s = idle();
            if (c == 3) begin
                s.meta_v = 1'b1;
                s.way    = 3'd2;
            end
            step(s);
            chk($sformatf("amo_wait%0d_valid", c), 64'(act_v), 64'd0);
        end
        step(idle());
        chk("amo_valid", 64'(act_v), 64'd1);
        chk("amo_type", 64'(act_typ), 64'd5);
        chk("amo_data", act_data, 64'h5);
        chk("amo_no_return", 64'(act_nr), 64'd1);
        chk("amo_way", 64'(act_way), 64'd2);
        drain();

        // exhaust credits, then return two at once
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            s       = idle();
            s.req_v = 1'b1;
            s.typ   = 4'd2;
            s.addr  = 40'h200 + 40'(idx * 8);
            s.size  = 3'd2;
            step(s);
            if (last_exp_yumi) idx++;
        end
        if (idx < 4) timeoutFail("credit_fill");
        for (int c = 0; c < 10 && mq.size() != 0; c++) step(idle());
        s       = idle();
        s.req_v = 1'b1;
        s.typ   = 4'd2;
        step(s);
        chk("credit_limit_yumi", 64'(act_yumi), 64'd0);
        chk("credit_limit_full", 64'(act_full), 64'd1);
        for (int c = 0; c < 2; c++) begin
            s    = idle();
            s.cc = 1'b1;
            s.uc = 1'b1;
            step(s);
        end
        step(idle());
        chk("credit_return_empty", 64'(act_empty), 64'd1);

        // uncached mode refuses a miss; a uc_load is taken once the miss is withdrawn
        for (int c = 0; c < 5; c++) begin
            s       = idle();
            s.ucm   = 1'b1;
            s.sync  = 1'b0;
            s.req_v = 1'b1;
            s.typ   = 4'd1;
            s.addr  = 40'h300;
            step(s);
            chk($sformatf("ucm_miss%0d_yumi", c), 64'(act_yumi), 64'd0);
        end
        s       = idle();
        s.ucm   = 1'b1;
        s.sync  = 1'b0;
        s.req_v = 1'b1;
        s.typ   = 4'd2;
        s.addr  = 40'h308;
        s.size  = 3'd1;
        offer(s, 5, ok);
        if (!ok) timeoutFail("ucm_uc_load_accept");
        drain();

        // address interleaving across four CCEs
        sent_dst.delete();
        idx = 0;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            s        = idle();
            s.req_v  = 1'b1;
            s.typ    = 4'd0;
            s.addr   = 40'(idx * 64);
            s.meta_v = 1'b1;
            s.way    = 3'(idx);
            step(s);
            if (last_exp_yumi) idx++;
        end
        if (idx < 4) timeoutFail("dst_accept");
        drain();
        if (sent_dst.size() != 4) begin
            timeoutFail("dst_count");
        end else begin
            for (int i = 0; i < 4; i++) chk($sformatf("dst%0d", i), 64'(sent_dst[i]), 64'(i));
        end

        // reset with two entries queued
        idx = 0;
        for (int c = 0; c < 10 && idx < 2; c++) begin
            s       = idle();
            s.ready = 1'b0;
            s.req_v = 1'b1;
            s.typ   = 4'd2;
            s.addr  = 40'h400 + 40'(idx * 8);
            step(s);
            if (last_exp_yumi) idx++;
        end
        if (idx < 2) timeoutFail("reset_fill");
        s       = idle();
        s.req_v = 1'b1;
        s.typ   = 4'd2;
        applyStimulus(s);
        reset_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(lce_v), 64'd0);
        chk("midreset_yumi", 64'(req_yumi), 64'd0);
        modelReset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("midreset_hold%0d_valid", c), 64'(lce_v), 64'd0);
        end
        applyStimulus(idle());
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(idle());
            chk($sformatf("postreset%0d_valid", c), 64'(act_v), 64'd0);
        end

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            s       = idle();
            s.req_v = ($urandom_range(1, 0) == 1);
            s.typ   = has_pending() ? 4'($urandom_range(3, 2)) : 4'($urandom_range(12, 0));
            s.addr  = 40'({$urandom(), $urandom()});
            s.size  = 3'($urandom_range(7, 0));
            s.data  = {$urandom(), $urandom()};
            s.nr    = ($urandom_range(1, 0) == 1);
            s.meta_v = has_pending() ? ($urandom_range(1, 0) == 1) : ($urandom_range(4, 0) == 0);
            s.way   = 3'($urandom_range(7, 0));
            s.ready = ($urandom_range(9, 0) < 7);
            s.cc    = (m_cred > 0) && ($urandom_range(3, 0) == 0);
            s.uc    = ((m_cred - int'(s.cc)) > 0) && ($urandom_range(3, 0) == 0);
            s.ucm   = ($urandom_range(9, 0) == 0);
            s.sync  = ($urandom_range(9, 0) != 0);
            step(s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bp_lce_req_queue.md
Name: bp_lce_req_queue

Overview:
- Next-generation LCE request engine that sits between a cache's miss/uncached/AMO request port and the LCE request network toward the CCEs.
- Buffers up to req_els_p cache requests in an in-order queue, so the cache is released before the network accepts the message.
- Attaches late-arriving replacement metadata to the queued request, handles AMOs end to end, and spreads requests across num_cce_p CCEs by address.
- Tracks outstanding transactions with a credit counter that accepts two completions in one cycle.

Parameters:
- req_els_p, 2, request queue depth (≥1).
- credits_p, 8, maximum outstanding sent requests.
- non_excl_reads_p, 0, 1 = miss loads are sent as non-exclusive.
- paddr_width_p, 40, physical address width.
- block_size_in_bytes_p, 64, cache block size; power of 2, 8..128.
- lce_id_width_p, 4, LCE id width.
- cce_id_width_p, 4, CCE id width.
- num_cce_p, 1, number of CCEs; power of 2, ≤ 2^cce_id_width_p.
- assoc_p, 8, cache associativity; way width is lg_assoc = clog2(assoc_p), minimum 1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- lce_id_i  in  lce_id_width_p  this LCE's id; copied to src_id.
- uncached_mode_i  in  1  1 = only uncached and AMO requests are accepted.
- sync_done_i  in  1  coherence sync complete.
- cache_req_v_i  in  1  request valid.
- cache_req_yumi_o  out  1  request consumed.
- cache_req_type_i  in  4  request type: 0 miss_load, 1 miss_store, 2 uc_load, 3 uc_store, 4-12 amo swap/add/xor/and/or/min/max/minu/maxu.
- cache_req_addr_i  in  paddr_width_p  request address.
- cache_req_size_i  in  3  log2 of size in bytes.
- cache_req_data_i  in  64  store/AMO operand.
- cache_req_no_return_i  in  1  AMO result not needed.
- metadata_v_i  in  1  metadata valid.
- metadata_way_i  in  lg_assoc  replacement way, or hit way for AMOs.
- cache_complete_i  in  1  completion pulse for a cached request.
- uc_complete_i  in  1  completion pulse for an uncached request or AMO.
- credits_full_o  out  1  credit count == credits_p.
- credits_empty_o  out  1  credit count == 0.
- lce_req_v_o  out  1  message valid.
- lce_req_ready_i  in  1  network ready; a message transfers on v & ready.
- lce_req_type_o  out  4  message type, same encoding as cache_req_type_i.
- lce_req_addr_o  out  paddr_width_p  message address.
- lce_req_size_o  out  3  message size.
- lce_req_data_o  out  64  message data.
- lce_req_way_o  out  lg_assoc  LRU or hit way.
- lce_req_non_excl_o  out  1  non-exclusive read.
- lce_req_amo_no_return_o  out  1  AMO no-return.
- lce_req_src_id_o  out  lce_id_width_p  source LCE id.
- lce_req_dst_id_o  out  cce_id_width_p  destination CCE id.
- stat_sent_o  out  32  count of transferred messages.
- stat_stall_o  out  32  cycles with lce_req_v_o=1 and lce_req_ready_i=0.

Behaviour:
- Reset: asynchronous on reset_n_i low. Queue empty, credit count 0, meta-pending flag 0, stats 0, lce_req_v_o=0, cache_req_yumi_o=0, credits_empty_o=1, credits_full_o=0.
- Acceptance: cache_req_yumi_o = cache_req_v_i & !queue_full & (credits + queued < credits_p) & mode_ok.
  - mode_ok for types 0-1 requires sync_done_i & !uncached_mode_i.
  - mode_ok for types 2-12 requires sync_done_i | uncached_mode_i.
  - A request that fails mode_ok is held by the cache, never dropped.
  - Enqueue while full is refused, even if the head dequeues in the same cycle.
- Metadata:
  - Types 0, 1 and 4-12 enqueue with need_meta=1; types 2-3 enqueue with need_meta=0.
  - metadata_v_i arrives in the acceptance cycle or any later cycle, and always before the next need_meta request.
  - Metadata writes way and clears need_meta on the youngest need_meta entry.
  - If metadata arrives in the acceptance cycle, it binds to the entry being accepted.
- Send:
  - lce_req_v_o = queue non-empty & !head.need_meta. There is no combinational path from lce_req_ready_i to lce_req_v_o.
  - Head pops on v & ready. Minimum latency is one cycle: accept in cycle N, lce_req_v_o=1 in N+1.
  - Messages leave in strict FIFO order.
- Field rules:
  - Types 0/1: size = log2(block_size_in_bytes_p); addr aligned down to the block; non_excl = (type==0) & non_excl_reads_p.
  - Types 2/3 and AMOs: size and address pass through unchanged.
  - data is zero except for types 3-12.
  - dst_id = addr[log2(block_size_in_bytes_p) +: log2(num_cce_p)], zero-extended; dst_id = 0 when num_cce_p = 1.
- Credits:
  - +1 on each transfer; −cache_complete_i − uc_complete_i each cycle. Net change is in −2..+1.
  - A completion while the count is 0 is illegal (assertion); the count saturates at 0.
- Reset mid-operation: all queued entries are discarded; no message is emitted afterwards.

Optional Feature:
- BP_LCE_REQ_STATS_EN defined: stat_sent_o and stat_stall_o count as specified and wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package bp_lce_req_queue_pkg holds:
  - the request-type enum and its message-type mapping;
  - the queue entry struct (type, addr, size, data, no_return, way, need_meta);
  - the helper that computes block-size log2.
- Sub-module bp_lce_req_credit_counter: up/down counter with +1/−2 inputs and full/empty outputs, parameter els_p.

Test Plan:
- miss_load to addr 0x8000_0047, metadata way 3 one cycle later, ready=1 → message type 0, addr 0x8000_0040, size 6, way 3, non_excl 0, sent two cycles after acceptance; count goes 0→1; cache_complete_i → 0.
- Three uc_store requests back-to-back with req_els_p=2 and ready=0 → two accepted, third held (yumi=0); ready=1 → messages drain in order and the third is accepted.
- amo_add with no_return=1, data 0x5, way metadata 2 delayed 4 cycles → lce_req_v_o stays 0 for 4 cycles, then type 5, data 0x5, amo_no_return 1, way 2.
- credits_p=2 with two sends outstanding → yumi=0 and credits_full_o=1; cache_complete_i and uc_complete_i pulsed together → count 0, credits_empty_o=1.
- uncached_mode_i=1, miss_store presented → never accepted; a uc_load queued behind it in the test sequence is accepted once the miss is withdrawn.
- num_cce_p=4, miss loads to addrs 0x00, 0x40, 0x80, 0xC0 → dst_id 0, 1, 2, 3; reset_n_i asserted with 2 entries queued → lce_req_v_o=0 immediately and stays 0.
